// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port memory.
// Each granted access runs issue -> optional read wait -> one-cycle acknowledge.
module mem_port_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          CK,
  input  logic          RST,
  input  logic          REQ0,
  input  logic          WE0,
  input  logic [AW-1:0] ADDR0,
  input  logic [DW-1:0] WDATA0,
  output logic          ACK0,
  output logic [DW-1:0] RDATA0,
  input  logic          REQ1,
  input  logic          WE1,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WDATA1,
  output logic          ACK1,
  output logic [DW-1:0] RDATA1,
  output logic [AW-1:0] MA,
  output logic [DW-1:0] MDO,
  output logic          MRW,
  output logic          MEN,
  input  logic [DW-1:0] MDI,
  output logic          BUSY,
  output logic          LAST
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [1:0]    cnt_r, cnt_s;
  logic          grant_s, port_s, cap_s;
  logic          we_r;
  logic [AW-1:0] ma_r;
  logic [DW-1:0] mdo_r, rdata0_r, rdata1_r;
  logic          ack0_r, ack1_r, men_r, mrw_r, last_r, busy_r;
  logic          sel_we_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;

  // Next-state decode: round-robin grant in IDLE, read-latency countdown in WAIT.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    grant_s = 1'b0;
    port_s  = last_r;
    cap_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (REQ0 && REQ1) begin
          grant_s = 1'b1;
          port_s  = ~last_r;
        end else if (REQ0) begin
          grant_s = 1'b1;
          port_s  = 1'b0;
        end else if (REQ1) begin
          grant_s = 1'b1;
          port_s  = 1'b1;
        end else begin
          grant_s = 1'b0;
        end
        if (grant_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (we_r) begin
          state_s = DONE;
        end else if (RD_LAT == 1) begin
          // Single-cycle memory: MDI is already valid while the strobe is up.
          cap_s   = 1'b1;
          state_s = DONE;
        end else begin
          cnt_s   = 2'(RD_LAT - 1);
          state_s = WAIT;
        end
      end
      WAIT: begin
        if (cnt_r == 2'd1) begin
          cap_s   = 1'b1;
          cnt_s   = 2'd0;
          state_s = DONE;
        end else begin
          cnt_s   = cnt_r - 2'd1;
          state_s = WAIT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign sel_we_s    = port_s ? WE1    : WE0;
  assign sel_addr_s  = port_s ? ADDR1  : ADDR0;
  assign sel_wdata_s = port_s ? WDATA1 : WDATA0;

  // State, captured request and all registered outputs.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_r  <= IDLE;
      cnt_r    <= 2'd0;
      we_r     <= 1'b0;
      ma_r     <= '0;
      mdo_r    <= '0;
      rdata0_r <= '0;
      rdata1_r <= '0;
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      men_r    <= 1'b0;
      mrw_r    <= 1'b1;
      last_r   <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      busy_r  <= (state_s != IDLE);
      men_r   <= grant_s;
      // The capture registers double as the memory pins, so MA/MDO hold between accesses.
      if (grant_s) begin
        we_r   <= sel_we_s;
        ma_r   <= sel_addr_s;
        mdo_r  <= sel_wdata_s;
        last_r <= port_s;
        mrw_r  <= ~sel_we_s;
      end else begin
        mrw_r  <= 1'b1;
      end
      ack0_r <= (state_s == DONE) && !last_r;
      ack1_r <= (state_s == DONE) && last_r;
      if (cap_s) begin
        if (last_r) begin
          rdata1_r <= MDI;
        end else begin
          rdata0_r <= MDI;
        end
      end
    end
  end

  assign ACK0   = ack0_r;
  assign ACK1   = ack1_r;
  assign RDATA0 = rdata0_r;
  assign RDATA1 = rdata1_r;
  assign MA     = ma_r;
  assign MDO    = mdo_r;
  assign MRW    = mrw_r;
  assign MEN    = men_r;
  assign BUSY   = busy_r;
  assign LAST   = last_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance with RD_LAT=1 (index 0) and one with RD_LAT=3 (index 1).
// A behavioural memory drives MDI; expectations come from a transaction-level reference model.
module tb_mem_port_arbiter;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic        rst [2];
  logic        seed;
  logic        req0 [2], we0 [2], req1 [2], we1 [2];
  logic [15:0] addr0 [2], wdata0 [2], addr1 [2], wdata1 [2];
  logic        ack0 [2], ack1 [2], mrw [2], men [2], busy [2], last [2];
  logic [15:0] rdata0 [2], rdata1 [2], ma [2], mdo [2], mdi [2];

  int vectors = 0;
  int miscompares = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(.AW(16), .DW(16), .RD_LAT(g == 0 ? 1 : 3)) dut (
      .CK(ck), .RST(rst[g]),
      .REQ0(req0[g]), .WE0(we0[g]), .ADDR0(addr0[g]), .WDATA0(wdata0[g]),
      .ACK0(ack0[g]), .RDATA0(rdata0[g]),
      .REQ1(req1[g]), .WE1(we1[g]), .ADDR1(addr1[g]), .WDATA1(wdata1[g]),
      .ACK1(ack1[g]), .RDATA1(rdata1[g]),
      .MA(ma[g]), .MDO(mdo[g]), .MRW(mrw[g]), .MEN(men[g]), .MDI(mdi[g]),
      .BUSY(busy[g]), .LAST(last[g])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [15:0] seed_val(input int i);
    if (i == 32'h20) return 16'h1234;
    if (i == 32'h03) return 16'hA5A5;
    return 16'(i * 40503) ^ 16'h5A5A;
  endfunction

  // Behavioural memory: MDI carries mem[addr] only in cycle RD_LAT counting the strobe cycle as 1.
  logic [15:0] sram [2][256];
  int          age [2];
  bit   [15:0] lat_addr [2];

  always @(posedge ck) begin
    for (int d = 0; d < 2; d++) begin
      if (seed) begin
        for (int i = 0; i < 256; i++) sram[d][i] <= seed_val(i);
      end else if (men[d] && !mrw[d]) begin
        sram[d][ma[d][7:0]] <= mdo[d];
      end
      if (men[d]) begin
        age[d]      <= 2;
        lat_addr[d] <= ma[d];
      end else if (age[d] < 8) begin
        age[d] <= age[d] + 1;
      end
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      int          cur;
      logic [15:0] a;
      logic [15:0] v;
      cur    = men[d] ? 1 : age[d];
      a      = men[d] ? ma[d] : lat_addr[d];
      v      = sram[d][a[7:0]];
      mdi[d] = (cur == lat_of(d)) ? v : ~v;
    end
  end

  // Reference model state
  logic [15:0] ref_mem [2][256];
  logic [15:0] ref_rd [2][2];
  logic        ref_last [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int d);
    ref_rd[d][0] = 16'h0000;
    ref_rd[d][1] = 16'h0000;
    ref_last[d]  = 1'b1;
  endtask

  task automatic drive(input int d, input bit p, input bit r, input bit w,
                       input logic [15:0] a, input logic [15:0] wd);
    if (p) begin
      req1[d] = r; we1[d] = w; addr1[d] = a; wdata1[d] = wd;
    end else begin
      req0[d] = r; we0[d] = w; addr0[d] = a; wdata0[d] = wd;
    end
  endtask

  task automatic check_reset(input int d);
    chk($sformatf("d%0d rst ACK0", d), ack0[d], 0);
    chk($sformatf("d%0d rst ACK1", d), ack1[d], 0);
    chk($sformatf("d%0d rst MEN", d), men[d], 0);
    chk($sformatf("d%0d rst MRW", d), mrw[d], 1);
    chk($sformatf("d%0d rst MA", d), ma[d], 0);
    chk($sformatf("d%0d rst MDO", d), mdo[d], 0);
    chk($sformatf("d%0d rst RDATA0", d), rdata0[d], 0);
    chk($sformatf("d%0d rst RDATA1", d), rdata1[d], 0);
    chk($sformatf("d%0d rst LAST", d), last[d], 1);
    chk($sformatf("d%0d rst BUSY", d), busy[d], 0);
  endtask

  task automatic apply_reset();
    @(negedge ck);
    rst[0] = 1'b1; rst[1] = 1'b1;
    @(negedge ck);
    for (int d = 0; d < 2; d++) begin
      check_reset(d);
      model_reset(d);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
  endtask

  // One access on port p of instance d; optionally scrambles the inputs right after the grant.
  task automatic xact(input int d, input bit p, input bit we, input logic [15:0] a,
                      input logic [15:0] wd, input bit scramble);
    int          e;
    logic [15:0] exp_rd;
    e      = we ? 2 : 1 + lat_of(d);
    exp_rd = ref_mem[d][a[7:0]];
    @(negedge ck);
    drive(d, p, 1'b1, we, a, wd);
    for (int k = 1; k <= e + 1; k++) begin
      @(negedge ck);
      chk($sformatf("d%0d c%0d MEN", d, k), men[d], (k == 1));
      chk($sformatf("d%0d c%0d MRW", d, k), mrw[d], (k == 1) ? !we : 1'b1);
      chk($sformatf("d%0d c%0d MA", d, k), ma[d], a);
      chk($sformatf("d%0d c%0d MDO", d, k), mdo[d], wd);
      chk($sformatf("d%0d c%0d BUSY", d, k), busy[d], (k <= e));
      chk($sformatf("d%0d c%0d LAST", d, k), last[d], p);
      chk($sformatf("d%0d c%0d ACK0", d, k), ack0[d], (!p && k == e));
      chk($sformatf("d%0d c%0d ACK1", d, k), ack1[d], (p && k == e));
      if (k == e) begin
        if (we) ref_mem[d][a[7:0]] = wd;
        else ref_rd[d][p] = exp_rd;
        ref_last[d] = p;
        chk($sformatf("d%0d RDATA0", d), rdata0[d], ref_rd[d][0]);
        chk($sformatf("d%0d RDATA1", d), rdata1[d], ref_rd[d][1]);
        drive(d, p, 1'b0, we, a, wd);
      end
      if (k == 1 && scramble) drive(d, p, 1'b1, !we, a + 16'h0010, ~wd);
    end
  endtask

  // Both ports request writes continuously right after reset: grants alternate 0,1,0,1.
  task automatic contend(input int d);
    int n;
    @(negedge ck);
    drive(d, 1'b0, 1'b1, 1'b1, 16'h0080, 16'hC0DE + 16'(d));
    drive(d, 1'b1, 1'b1, 1'b1, 16'h0081, 16'h0BAD + 16'(d));
    for (int k = 1; k <= 12; k++) begin
      @(negedge ck);
      n = (k - 1) / 3;
      chk($sformatf("d%0d arb c%0d LAST", d, k), last[d], n % 2);
      chk($sformatf("d%0d arb c%0d BUSY", d, k), busy[d], (k % 3 != 0));
      chk($sformatf("d%0d arb c%0d MEN", d, k), men[d], (k % 3 == 1));
      chk($sformatf("d%0d arb c%0d ACK0", d, k), ack0[d], (k % 3 == 2) && (((k - 2) / 3) % 2 == 0));
      chk($sformatf("d%0d arb c%0d ACK1", d, k), ack1[d], (k % 3 == 2) && (((k - 2) / 3) % 2 == 1));
      if (k == 11) begin
        req0[d] = 1'b0;
        req1[d] = 1'b0;
      end
    end
    ref_mem[d][8'h80] = 16'hC0DE + 16'(d);
    ref_mem[d][8'h81] = 16'h0BAD + 16'(d);
    ref_last[d] = 1'b1;
  endtask

  initial begin
    seed = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      drive(d, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      drive(d, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      for (int i = 0; i < 256; i++) ref_mem[d][i] = seed_val(i);
      model_reset(d);
    end
    @(negedge ck);
    seed = 1'b0;
    for (int d = 0; d < 2; d++) check_reset(d);
    rst[0] = 1'b0; rst[1] = 1'b0;

    for (int d = 0; d < 2; d++) begin
      xact(d, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
      xact(d, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
      xact(d, 1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0);
      xact(d, 1'b0, 1'b1, 16'h0040, 16'h7777, 1'b1);
      xact(d, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0);
      xact(d, 1'b0, 1'b0, 16'h0050, 16'h0000, 1'b0);
      xact(d, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    end

    apply_reset();
    contend(0);
    contend(1);
    xact(0, 1'b0, 1'b0, 16'h0081, 16'h0000, 1'b0);
    xact(1, 1'b1, 1'b0, 16'h0080, 16'h0000, 1'b0);

    // Reset during the first WAIT cycle of a RD_LAT=3 read.
    xact(1, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0);
    @(negedge ck);
    drive(1, 1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000);
    @(negedge ck);
    chk("d1 rr ISSUE MEN", men[1], 1);
    @(negedge ck);
    chk("d1 rr WAIT BUSY", busy[1], 1);
    rst[1] = 1'b1;
    drive(1, 1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000);
    @(negedge ck);
    rst[1] = 1'b0;
    check_reset(1);
    model_reset(1);
    for (int k = 0; k < 4; k++) begin
      @(negedge ck);
      chk($sformatf("d1 rr post%0d ACK0", k), ack0[1], 0);
      chk($sformatf("d1 rr post%0d ACK1", k), ack1[1], 0);
      chk($sformatf("d1 rr post%0d RDATA0", k), rdata0[1], 0);
      chk($sformatf("d1 rr post%0d BUSY", k), busy[1], 0);
    end
    xact(1, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);

    for (int i = 0; i < 60; i++) begin
      xact(int'($urandom_range(0, 1)), 1'($urandom), 1'($urandom),
           16'($urandom_range(0, 255)), 16'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
